// File: rtl/mealy_table_fsm.sv
// Table-driven Mealy FSM: a writable {next_state, out} table indexed by {state, in_data}.
// Optional macro MEALY_FSM_OUT_REG_EN registers out_data/out_valid (one-cycle latency).
module mealy_table_fsm #(
  parameter int STATE_W     = 2,
  parameter int IN_W        = 2,
  parameter int OUT_W       = 2,
  parameter int RESET_STATE = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_we,
  input  logic [STATE_W+IN_W-1:0]  cfg_addr,
  input  logic [STATE_W+OUT_W-1:0] cfg_data,
  input  logic                     run,
  input  logic                     restart,
  input  logic                     in_valid,
  input  logic [IN_W-1:0]          in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [OUT_W-1:0]         out_data,
  output logic [STATE_W-1:0]       state,
  output logic [15:0]              step_count
);

  localparam int ADDR_W = STATE_W + IN_W;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct packed {
    logic [STATE_W-1:0] next_state;
    logic [OUT_W-1:0]   out;
  } entry_t;

  entry_t table_q [DEPTH];
  entry_t lookup;
  logic   step;

  // Restart and table writes both steal the cycle from stepping.
  assign in_ready = run & ~cfg_we & ~restart;
  assign step     = in_valid & in_ready;
  assign lookup   = table_q[{state, in_data}];

  // NOTE: the table is flops, not RAM, so every entry can be cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
    end else if (cfg_we) begin
      table_q[cfg_addr] <= entry_t'(cfg_data);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= STATE_W'(RESET_STATE);
      step_count <= '0;
    end else if (restart) begin
      state      <= STATE_W'(RESET_STATE);
      step_count <= '0;
    end else if (step) begin
      state <= lookup.next_state;
      if (step_count != 16'hFFFF) step_count <= step_count + 16'd1;
    end
  end

`ifdef MEALY_FSM_OUT_REG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (step) begin
      out_valid <= 1'b1;
      out_data  <= lookup.out;
    end else begin
      out_valid <= 1'b0;
    end
  end
`else
  assign out_valid = step;
  assign out_data  = lookup.out;
`endif

endmodule
